// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//   Round-robin arbiter sharing one single-port synchronous ROM (1-cycle
//   registered read) among NUM_REQ requesters. At most one request is accepted
//   per cycle. The read data comes back one cycle later on rsp_*, tagged with
//   the index of the requester that owns it. A per-requester lock hint grants
//   short bursts of up to MAX_BURST consecutive accepts to one requester.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   en           : global grant enable
//   req_valid    : per-requester request
//   req_lock     : per-requester burst lock hint, sampled with req_valid
//   req_addr     : flattened addresses, requester i at [i*AW +: AW]
//   req_ready    : one-hot acceptance (combinational)
//   rsp_valid    : registered response strobe
//   rsp_id       : index of the requester owning rsp_data
//   rsp_data     : read data (ROM output passed through while rsp_valid=1)
//   rom_en       : ROM read enable (combinational)
//   rom_addr     : ROM address (combinational)
//   rom_data     : ROM registered output
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int MAX_BURST = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    output logic [IW-1:0]         rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rom_en,
    output logic [AW-1:0]         rom_addr,
    input  logic [WIDTH-1:0]      rom_data
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW:0]   NR_W     = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    // Last burst count value that still allows one more locked grant.
    localparam logic [BW-1:0] CNT_LAST = BW'(MAX_BURST - 1);

    logic [IW-1:0]    ptr_r;
    logic [IW-1:0]    ptr_s;
    logic [BW-1:0]    burst_cnt_r;
    logic [BW-1:0]    burst_cnt_s;
    logic             rsp_valid_r;
    logic [IW-1:0]    rsp_id_r;

    logic             found_s;
    logic [IW-1:0]    win_s;
    logic [IW-1:0]    win_inc_s;
    logic             fresh_s;
    logic [AW-1:0]    addr_a [NUM_REQ];

    // Unpack the flattened address bus so it can be indexed by requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
            assign addr_a[gi] = req_addr[gi*AW +: AW];
        end
    endgenerate

    // Round-robin search starting at ptr; the modulo wrap is explicit so
    // non-power-of-two NUM_REQ works.
    always_comb begin : select
        logic [IW:0]   sum_v;
        logic [IW-1:0] idx_v;
        found_s = 1'b0;
        win_s   = '0;
        sum_v   = '0;
        idx_v   = '0;
        if (!rst && en) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                sum_v = {1'b0, ptr_r} + (IW+1)'(i);
                if (sum_v >= NR_W) begin
                    sum_v = sum_v - NR_W;
                end else begin
                    sum_v = sum_v;
                end
                idx_v = sum_v[IW-1:0];
                if (!found_s && req_valid[idx_v]) begin
                    found_s = 1'b1;
                    win_s   = idx_v;
                end else begin
                    found_s = found_s;
                end
            end
        end else begin
            found_s = 1'b0;
        end
    end

    // Grant outputs and ROM drive derived from the selected winner.
    always_comb begin
        req_ready = '0;
        rom_en    = 1'b0;
        rom_addr  = '0;
        if (found_s) begin
            req_ready[win_s] = 1'b1;
            rom_en           = 1'b1;
            rom_addr         = addr_a[win_s];
        end else begin
            rom_en = 1'b0;
        end
    end

    // Next pointer and burst count. A burst continues only while the same
    // requester keeps winning with lock set; any other grant starts afresh.
    always_comb begin
        win_inc_s   = (win_s == LAST_IDX) ? '0 : win_s + IW'(1);
        fresh_s     = (burst_cnt_r == '0) || (win_s != rsp_id_r);
        ptr_s       = ptr_r;
        burst_cnt_s = burst_cnt_r;
        if (!found_s) begin
            ptr_s       = ptr_r;
            burst_cnt_s = burst_cnt_r;
        end else if (fresh_s) begin
            if (req_lock[win_s] && (CNT_LAST != '0)) begin
                ptr_s       = win_s;
                burst_cnt_s = BW'(1);
            end else begin
                ptr_s       = win_inc_s;
                burst_cnt_s = '0;
            end
        end else if (req_lock[win_s] && (burst_cnt_r < CNT_LAST)) begin
            ptr_s       = win_s;
            burst_cnt_s = burst_cnt_r + BW'(1);
        end else begin
            ptr_s       = win_inc_s;
            burst_cnt_s = '0;
        end
    end

    // State and response registers; rsp_id doubles as the previous winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r       <= '0;
            burst_cnt_r <= '0;
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            ptr_r       <= ptr_s;
            burst_cnt_r <= burst_cnt_s;
            rsp_valid_r <= found_s;
            if (found_s) begin
                rsp_id_r <= win_s;
            end else begin
                rsp_id_r <= rsp_id_r;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    // ROM output is already registered; gate it so idle cycles read as zero.
    assign rsp_data  = rsp_valid_r ? rom_data : '0;

endmodule
